// File: rtl/axis_requantizer.sv
// -----------------------------------------------------------------------------
// axis_requantizer
//
// Takes the 256-bit stream of 16 unsigned 16-bit weighted products coming out
// of the beamforming weight multiplier and requantizes each lane back to
// 8 bits: right shift with round-half-up, then saturate to 0xFF. The result
// is a 128-bit stream for the next 8-bit stage or DMA.
//
// The shift amount is taken from the shift port on the first beat of each
// frame and held for the rest of the frame. Output is a single register
// backed by a one-entry skid register, so the block runs at one beat per
// clock while the sink is ready, and s_axis_tready comes straight from a flop.
// Saturated lanes are counted per input frame.
//
// Ports
//   CLK, resetn        clock, synchronous active-low reset
//   s_axis_tdata       16 input lanes, lane i at [i*16 +: 16]
//   s_axis_tkeep       per-lane valid (masked lanes emit 0x00, never saturate)
//   s_axis_tvalid/ready/last  input AXI-Stream handshake and end of frame
//   shift              right-shift amount, sampled on the first beat of a frame
//   m_axis_tdata       16 output lanes, lane i at [i*8 +: 8]
//   m_axis_tkeep/last  passed through with the beat
//   m_axis_tvalid/ready       output AXI-Stream handshake
//   frame_done         one-cycle pulse after the input tlast beat is accepted
//   frame_sat_count    saturated-lane count of the last completed input frame
// -----------------------------------------------------------------------------
module axis_requantizer #(
    parameter int SDATA_WIDTH   = 256,
    parameter int SSAMPLE_WIDTH = 16,
    parameter int MSAMPLE_WIDTH = 8,
    parameter int SHIFT_WIDTH   = 4,
    localparam int SAMPLES      = SDATA_WIDTH / SSAMPLE_WIDTH
) (
    input  logic                               CLK,
    input  logic                               resetn,
    input  logic [SDATA_WIDTH-1:0]             s_axis_tdata,
    input  logic [SAMPLES-1:0]                 s_axis_tkeep,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    input  logic [SHIFT_WIDTH-1:0]             shift,
    output logic [SAMPLES*MSAMPLE_WIDTH-1:0]   m_axis_tdata,
    output logic [SAMPLES-1:0]                 m_axis_tkeep,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic                               frame_done,
    output logic [15:0]                        frame_sat_count
);

    localparam int OUT_W = SAMPLES * MSAMPLE_WIDTH;
    localparam int PW    = SSAMPLE_WIDTH + 1;       // widened product, room for the rounding carry
    localparam int CNT_W = $clog2(SAMPLES + 1);

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    state_t                 state_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [SHIFT_WIDTH-1:0] shift_eff;

    // Requantized view of the beat currently on the input port
    logic [OUT_W-1:0]       beat_data;
    logic [SAMPLES-1:0]     lane_sat;
    logic [CNT_W-1:0]       beat_sat_cnt;

    // Output register and skid register
    logic                   out_valid_q;
    logic [OUT_W-1:0]       out_data_q;
    logic [SAMPLES-1:0]     out_keep_q;
    logic                   out_last_q;
    logic                   skid_valid_q;
    logic                   skid_valid_d;
    logic [OUT_W-1:0]       skid_data_q;
    logic [SAMPLES-1:0]     skid_keep_q;
    logic                   skid_last_q;
    logic                   s_ready_q;

    // Statistics
    logic [15:0]            sat_cnt_q;
    logic [15:0]            sat_cnt_d;
    logic [16:0]            sat_sum;
    logic                   frame_done_q;
    logic [15:0]            frame_sat_q;

    logic                   accept;

    assign accept    = s_axis_tvalid & s_ready_q;
    // First beat of a frame uses the live port value, later beats the latched one
    assign shift_eff = (state_q == IDLE) ? shift : shift_q;

    // -------------------------------------------------------------------------
    // Per-lane shift / round / saturate
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < SAMPLES; gi++) begin : g_lane
        logic [PW-1:0] p_ext;
        logic [PW-1:0] rnd;
        logic [PW-1:0] r;

        assign p_ext = {1'b0, s_axis_tdata[gi*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]};
        // Half an output LSB; the 17-bit sum cannot wrap even at 0xFFFF
        assign rnd   = (shift_eff == '0) ? '0 : (PW'(1) << (shift_eff - SHIFT_WIDTH'(1)));
        assign r     = (p_ext + rnd) >> shift_eff;

        assign lane_sat[gi] = s_axis_tkeep[gi] & (|r[PW-1:MSAMPLE_WIDTH]);
        assign beat_data[gi*MSAMPLE_WIDTH +: MSAMPLE_WIDTH] =
            !s_axis_tkeep[gi] ? '0 :
            lane_sat[gi]      ? '1 : r[MSAMPLE_WIDTH-1:0];
    end

    always_comb begin
        beat_sat_cnt = '0;
        for (int i = 0; i < SAMPLES; i++) begin
            beat_sat_cnt = beat_sat_cnt + CNT_W'(lane_sat[i]);
        end
    end

    // Running frame count, clamped at 0xFFFF
    assign sat_sum   = {1'b0, sat_cnt_q} + 17'(beat_sat_cnt);
    assign sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

    // Skid fills only when a beat arrives while the output holds a stalled beat;
    // it always empties on the next cycle the sink is ready.
    always_comb begin
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            if (m_axis_tready) begin
                skid_valid_d = 1'b0;
            end
        end else if (accept && out_valid_q && !m_axis_tready) begin
            skid_valid_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State, datapath registers and statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_last_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            sat_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            frame_sat_q  <= '0;
        end else begin
            s_ready_q    <= !skid_valid_d;
            skid_valid_q <= skid_valid_d;

            // Output / skid movement. While the skid is full s_ready_q is low,
            // so no new beat can arrive in the same cycle it drains.
            if (skid_valid_q) begin
                if (m_axis_tready) begin
                    out_data_q <= skid_data_q;
                    out_keep_q <= skid_keep_q;
                    out_last_q <= skid_last_q;
                end
            end else if (accept) begin
                if (!out_valid_q || m_axis_tready) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= beat_data;
                    out_keep_q  <= s_axis_tkeep;
                    out_last_q  <= s_axis_tlast;
                end else begin
                    skid_data_q <= beat_data;
                    skid_keep_q <= s_axis_tkeep;
                    skid_last_q <= s_axis_tlast;
                end
            end else if (m_axis_tready) begin
                out_valid_q <= 1'b0;
            end

            // Frame tracking
            frame_done_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        shift_q <= shift;
                        if (!s_axis_tlast) begin
                            state_q <= IN_FRAME;
                        end
                    end
                    IN_FRAME: begin
                        if (s_axis_tlast) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase

                if (s_axis_tlast) begin
                    frame_sat_q  <= sat_cnt_d;
                    frame_done_q <= 1'b1;
                    sat_cnt_q    <= '0;
                end else begin
                    sat_cnt_q    <= sat_cnt_d;
                end
            end
        end
    end

    assign s_axis_tready   = s_ready_q;
    assign m_axis_tvalid   = out_valid_q;
    assign m_axis_tdata    = out_data_q;
    assign m_axis_tkeep    = out_keep_q;
    assign m_axis_tlast    = out_last_q;
    assign frame_done      = frame_done_q;
    assign frame_sat_count = frame_sat_q;

endmodule

// File: tb/tb_axis_requantizer.sv
// -----------------------------------------------------------------------------
// tb_axis_requantizer
//
// Directed stimulus with hand-computed literal expectations, plus a
// behavioural model (queue of expected output beats, beat occupancy count,
// per-frame saturation total) checked against the DUT every cycle by one
// monitor process on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_requantizer;

    logic         CLK;
    logic         resetn;
    logic [255:0] s_axis_tdata;
    logic [15:0]  s_axis_tkeep;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [3:0]   shift;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic         frame_done;
    logic [15:0]  frame_sat_count;

    axis_requantizer dut (
        .CLK             (CLK),
        .resetn          (resetn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .shift           (shift),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .frame_done      (frame_done),
        .frame_sat_count (frame_sat_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    beat_t        exp_q[$];
    int           occ;          // beats held inside the DUT
    bit           in_frame;
    int           fshift;
    int           acc;
    bit           exp_fd;
    logic [15:0]  exp_fsc;
    bit           rst_prev;
    bit           mon_en = 0;
    bit           stalled;
    beat_t        held;

    always @(negedge CLK) begin
        int    sh;
        int    nsat;
        int    p;
        int    r;
        beat_t nb;
        beat_t e;
        bit    xfer;
        bit    acpt;
        if (!resetn) begin
            exp_q.delete();
            occ      = 0;
            in_frame = 0;
            fshift   = 0;
            acc      = 0;
            exp_fd   = 0;
            exp_fsc  = 16'h0000;
            rst_prev = 1;
            stalled  = 0;
            mon_en   = 1;
        end else if (mon_en) begin
            chk("frame_done", frame_done, exp_fd);
            chk("frame_sat_count", frame_sat_count, exp_fsc);
            chk("m_tvalid_occupancy", m_axis_tvalid, occ > 0);
            chk("s_tready_occupancy", s_axis_tready, !rst_prev && occ < 2);
            if (stalled) begin
                chk("stall_data", m_axis_tdata, held.d);
                chk("stall_keep", m_axis_tkeep, held.k);
                chk("stall_last", m_axis_tlast, held.l);
            end

            xfer = m_axis_tvalid && m_axis_tready;
            acpt = s_axis_tvalid && s_axis_tready;

            if (xfer) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output_beat", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", m_axis_tdata, e.d);
                    chk("out_keep", m_axis_tkeep, e.k);
                    chk("out_last", m_axis_tlast, e.l);
                end
                occ--;
            end

            exp_fd = 0;
            if (acpt) begin
                if (!in_frame) begin
                    sh     = int'(shift);
                    fshift = sh;
                end else begin
                    sh = fshift;
                end
                nsat = 0;
                for (int i = 0; i < 16; i++) begin
                    p = int'(s_axis_tdata[i*16 +: 16]);
                    if (!s_axis_tkeep[i]) begin
                        r = 0;
                    end else begin
                        r = (sh == 0) ? p : (p + (1 << (sh - 1))) / (1 << sh);
                        if (r > 255) begin
                            r = 255;
                            nsat++;
                        end
                    end
                    nb.d[i*8 +: 8] = r[7:0];
                end
                nb.k = s_axis_tkeep;
                nb.l = s_axis_tlast;
                exp_q.push_back(nb);
                occ++;
                acc = (acc + nsat > 65535) ? 65535 : acc + nsat;
                if (s_axis_tlast) begin
                    exp_fd   = 1;
                    exp_fsc  = acc[15:0];
                    acc      = 0;
                    in_frame = 0;
                end else begin
                    in_frame = 1;
                end
            end

            stalled  = m_axis_tvalid && !m_axis_tready;
            held.d   = m_axis_tdata;
            held.k   = m_axis_tkeep;
            held.l   = m_axis_tlast;
            rst_prev = 0;
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers (driver always sits 1 ns after a rising edge between calls)
    // ------------------------------------------------------------------------
    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [255:0] d, input logic [15:0] k, input logic l, input logic [3:0] sh);
        int n;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        shift         = sh;
        s_axis_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge CLK);
            if (s_axis_tready) begin
                sync();
                break;
            end
            n++;
            if (n > 50) begin
                chk("send_timeout", 1'b1, 1'b0);
                sync();
                break;
            end
            sync();
        end
        s_axis_tvalid = 1'b0;
    endtask

    function automatic logic [255:0] fill(input logic [15:0] v);
        return {16{v}};
    endfunction

    function automatic logic [255:0] bp_beat(input int j);
        logic [255:0] d;
        d = '0;
        d[15:0] = 16'h0100;
        for (int i = 1; i < 16; i++) begin
            d[i*16 +: 16] = 16'(j * 16 + i);
        end
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [255:0] d;

    initial begin
        resetn        = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        shift         = '0;
        m_axis_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tdata", m_axis_tdata, 128'h0);
        chk("rst_m_tkeep", m_axis_tkeep, 16'h0);
        chk("rst_m_tlast", m_axis_tlast, 1'b0);
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_frame_sat_count", frame_sat_count, 16'h0);
        sync();
        resetn = 1'b1;
        sync();

        // Rounding: 0x3F80 >> 7 with half-LSB rounding = 0x7F
        send(fill(16'h3F80), 16'hFFFF, 1'b1, 4'd7);
        @(negedge CLK);
        chk("t1_data", m_axis_tdata, {16{8'h7F}});
        chk("t1_keep", m_axis_tkeep, 16'hFFFF);
        chk("t1_last", m_axis_tlast, 1'b1);
        chk("t1_valid", m_axis_tvalid, 1'b1);
        chk("t1_frame_done", frame_done, 1'b1);
        chk("t1_sat_count", frame_sat_count, 16'd0);
        sync();

        // Saturation via rounding carry
        d = '0;
        d[15:0]  = 16'h0FF8;
        d[31:16] = 16'h0017;
        send(d, 16'hFFFF, 1'b1, 4'd4);
        @(negedge CLK);
        chk("t2a_data", m_axis_tdata, {112'h0, 8'h01, 8'hFF});
        chk("t2a_sat_count", frame_sat_count, 16'd1);
        sync();

        // 0xFFFF + 0x80 must not wrap in the widened sum
        send(fill(16'hFFFF), 16'hFFFF, 1'b1, 4'd8);
        @(negedge CLK);
        chk("t2b_data", m_axis_tdata, {16{8'hFF}});
        chk("t2b_sat_count", frame_sat_count, 16'd16);
        sync();

        // Shift 0 and tkeep masking
        d = '0;
        d[15:0]  = 16'h0100;
        d[31:16] = 16'h00AB;
        d[47:32] = 16'hFFFF;
        send(d, 16'h0003, 1'b1, 4'd0);
        @(negedge CLK);
        chk("t3_data", m_axis_tdata, {104'h0, 8'h00, 8'hAB, 8'hFF});
        chk("t3_keep", m_axis_tkeep, 16'h0003);
        chk("t3_sat_count", frame_sat_count, 16'd1);
        sync();

        // Shift latched on the first beat; port ignored for the rest of the frame
        send(fill(16'h0400), 16'hFFFF, 1'b0, 4'd7);
        @(negedge CLK);
        chk("t4_beat1", m_axis_tdata, {16{8'h08}});
        sync();
        send(fill(16'h0400), 16'hFFFF, 1'b0, 4'd2);
        @(negedge CLK);
        chk("t4_beat2", m_axis_tdata, {16{8'h08}});
        sync();
        send(fill(16'h0400), 16'hFFFF, 1'b1, 4'd2);
        @(negedge CLK);
        chk("t4_beat3", m_axis_tdata, {16{8'h08}});
        chk("t4_last", m_axis_tlast, 1'b1);
        chk("t4_frame_done", frame_done, 1'b1);
        sync();
        send(fill(16'h0100), 16'hFFFF, 1'b1, 4'd2);
        @(negedge CLK);
        chk("t4_next_frame", m_axis_tdata, {16{8'h40}});
        sync();

        // Backpressure: 8-beat burst, sink stalls for 3 cycles mid-burst
        fork
            begin
                for (int j = 0; j < 8; j++) begin
                    send(bp_beat(j), 16'hFFFF, j == 7, 4'd0);
                end
            end
            begin
                repeat (3) sync();
                m_axis_tready = 1'b0;
                repeat (3) sync();
                m_axis_tready = 1'b1;
            end
        join
        repeat (4) sync();
        @(negedge CLK);
        chk("t5_sat_count", frame_sat_count, 16'd8);
        chk("t5_all_delivered", 128'(exp_q.size()), 128'd0);
        sync();

        // Reset with output and skid both full, mid-frame
        m_axis_tready = 1'b0;
        send(fill(16'h0400), 16'hFFFF, 1'b0, 4'd7);
        send(fill(16'h0400), 16'hFFFF, 1'b0, 4'd7);
        @(negedge CLK);
        chk("t6_skid_full_ready", s_axis_tready, 1'b0);
        chk("t6_out_full_valid", m_axis_tvalid, 1'b1);
        sync();
        resetn = 1'b0;
        sync();
        resetn = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge CLK);
        chk("t6_rst_tvalid", m_axis_tvalid, 1'b0);
        chk("t6_rst_frame_done", frame_done, 1'b0);
        chk("t6_rst_sat_count", frame_sat_count, 16'd0);
        sync();
        @(negedge CLK);
        chk("t6_post_tready", s_axis_tready, 1'b1);
        chk("t6_post_tvalid", m_axis_tvalid, 1'b0);
        sync();
        send(fill(16'h0100), 16'hFFFF, 1'b1, 4'd2);
        @(negedge CLK);
        chk("t6_live_shift", m_axis_tdata, {16{8'h40}});
        sync();

        repeat (4) sync();
        @(negedge CLK);
        chk("final_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
